// File: rtl/voxel_class_decider.sv
// Serial best/second-best class decider with threshold, margin, enable mask and persistence.
// Optional debug taps are enabled by defining VOXEL_DECIDER_DEBUG_EN.
module voxel_class_decider #(
    parameter int NUM_CLASSES       = 4,
    parameter int ACC_BITS          = 24,
    parameter int MIN_SCORE_THRESH  = 30,
    parameter int MIN_MARGIN        = 0,
    parameter int PERSISTENCE_COUNT = 2,
    parameter int CONF_BITS         = 4,
    parameter int CONF_SHIFT        = 2,
    localparam int GW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat,
    input  logic                            scores_valid,
    output logic                            scores_ready,
    input  logic [NUM_CLASSES-1:0]          class_enable,
    output logic [GW-1:0]                   gesture,
    output logic                            gesture_valid,
    input  logic                            gesture_ready,
    output logic [CONF_BITS-1:0]            gesture_confidence,
    output logic [7:0]                      drop_count,
    output logic [ACC_BITS-1:0]             dbg_best_score,
    output logic [ACC_BITS:0]               dbg_margin
);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

    // Streak counter has headroom above the target so a held streak never re-hits it.
    localparam int STREAK_W = $clog2(PERSISTENCE_COUNT + 2);

    localparam logic signed [ACC_BITS-1:0] MIN_VAL    = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [ACC_BITS-1:0] THRESH     = ACC_BITS'(MIN_SCORE_THRESH);
    localparam logic signed [ACC_BITS:0]   MARGIN_MIN = (ACC_BITS+1)'(MIN_MARGIN);
    localparam logic signed [ACC_BITS:0]   MARGIN_MAX = {1'b0, {ACC_BITS{1'b1}}};
    localparam logic [ACC_BITS:0]          CONF_MAX   = (ACC_BITS+1)'((1 << CONF_BITS) - 1);
    localparam logic [STREAK_W-1:0]        PERSIST    = STREAK_W'(PERSISTENCE_COUNT);
    localparam logic [GW-1:0]              LAST_IDX   = GW'(NUM_CLASSES - 1);

    state_t                          state_q;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_q;
    logic [NUM_CLASSES-1:0]          enable_q;
    logic                            single_q;
    logic signed [ACC_BITS-1:0]      best_q;
    logic signed [ACC_BITS-1:0]      second_q;
    logic [GW-1:0]                   best_idx_q;
    logic [GW-1:0]                   idx_q;
    logic                            found_q;
    logic [STREAK_W-1:0]             streak_q;
    logic [GW-1:0]                   streak_class_q;
    logic [GW-1:0]                   gesture_q;
    logic                            gesture_valid_q;
    logic [CONF_BITS-1:0]            conf_q;
    logic [7:0]                      drop_q;

    logic signed [ACC_BITS-1:0] cur_score;
    logic signed [ACC_BITS:0]   margin_raw;
    logic signed [ACC_BITS:0]   margin_d;
    logic [ACC_BITS:0]          margin_u;
    logic                       pass_d;
    logic                       emit_d;
    logic [STREAK_W-1:0]        streak_d;
    logic [GW-1:0]              streak_class_d;
    logic [CONF_BITS-1:0]       conf_d;

    // The captured vector is shifted down each scan cycle, so class idx is always at the bottom.
    assign cur_score = scores_q[ACC_BITS-1:0];

    always_comb begin
        margin_raw     = {best_q[ACC_BITS-1], best_q} - {second_q[ACC_BITS-1], second_q};
        margin_d       = single_q ? MARGIN_MAX : margin_raw;
        pass_d         = found_q && (best_q >= THRESH) && (margin_d >= MARGIN_MIN);
        streak_d       = '0;
        streak_class_d = streak_class_q;
        if (pass_d) begin
            if (best_idx_q == streak_class_q) begin
                streak_d = (streak_q == '1) ? streak_q : streak_q + 1'b1;
            end else begin
                streak_class_d = best_idx_q;
                streak_d       = STREAK_W'(1);
            end
        end
        emit_d   = pass_d && (streak_d == PERSIST);
        margin_u = unsigned'(margin_d) >> CONF_SHIFT;
        conf_d   = (margin_u > CONF_MAX) ? CONF_BITS'(CONF_MAX) : margin_u[CONF_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            scores_q        <= '0;
            enable_q        <= '0;
            single_q        <= 1'b0;
            best_q          <= MIN_VAL;
            second_q        <= MIN_VAL;
            best_idx_q      <= '0;
            idx_q           <= '0;
            found_q         <= 1'b0;
            streak_q        <= '0;
            streak_class_q  <= '0;
            gesture_q       <= '0;
            gesture_valid_q <= 1'b0;
            conf_q          <= '0;
            drop_q          <= '0;
        end else begin
            if (gesture_valid_q && gesture_ready) begin
                gesture_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (scores_valid) begin
                        scores_q   <= scores_flat;
                        enable_q   <= class_enable;
                        single_q   <= ((class_enable & (class_enable - 1'b1)) == '0);
                        best_q     <= MIN_VAL;
                        second_q   <= MIN_VAL;
                        best_idx_q <= '0;
                        found_q    <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (enable_q[0]) begin
                        if (cur_score > best_q) begin
                            second_q   <= best_q;
                            best_q     <= cur_score;
                            best_idx_q <= idx_q;
                            found_q    <= 1'b1;
                        end else if (cur_score > second_q) begin
                            second_q <= cur_score;
                        end
                    end
                    scores_q <= scores_q >> ACC_BITS;
                    enable_q <= enable_q >> 1;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    streak_q       <= streak_d;
                    streak_class_q <= streak_class_d;
                    // A consumer taking the old result this same edge frees the slot for the new one.
                    if (emit_d) begin
                        if (!gesture_valid_q || gesture_ready) begin
                            gesture_q       <= best_idx_q;
                            conf_q          <= conf_d;
                            gesture_valid_q <= 1'b1;
                        end else if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign scores_ready       = (state_q == IDLE);
    assign gesture            = gesture_q;
    assign gesture_valid      = gesture_valid_q;
    assign gesture_confidence = conf_q;
    assign drop_count         = drop_q;

`ifdef VOXEL_DECIDER_DEBUG_EN
    logic signed [ACC_BITS-1:0] dbg_best_q;
    logic signed [ACC_BITS:0]   dbg_margin_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_best_q   <= '0;
            dbg_margin_q <= '0;
        end else if (state_q == DECIDE) begin
            dbg_best_q   <= best_q;
            dbg_margin_q <= margin_d;
        end
    end

    assign dbg_best_score = dbg_best_q;
    assign dbg_margin     = dbg_margin_q;
`else
    assign dbg_best_score = '0;
    assign dbg_margin     = '0;
`endif

endmodule

// File: tb/tb_voxel_class_decider.sv
// Self-checking bench for voxel_class_decider: directed cases plus randomized vectors
// compared every cycle against a transaction-level model of the decision rules.
module tb_voxel_class_decider;

    localparam int NC   = 4;
    localparam int AB   = 24;
    localparam int PC   = 2;
    localparam int THR  = 30;
    localparam int MM   = 0;
    localparam int CS   = 2;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NC*AB-1:0]  scores_flat;
    logic              scores_valid;
    logic              scores_ready;
    logic [NC-1:0]     class_enable;
    logic [1:0]        gesture;
    logic              gesture_valid;
    logic              gesture_ready;
    logic [3:0]        gesture_confidence;
    logic [7:0]        drop_count;
    logic [AB-1:0]     dbg_best_score;
    logic [AB:0]       dbg_margin;

    logic [AB-1:0]     s1_flat;
    logic              s1_valid;
    logic              s1_ready;
    logic              s1_enable;
    logic              s1_gesture;
    logic              s1_gv;
    logic              s1_gready;
    logic [3:0]        s1_conf;
    logic [7:0]        s1_drop;
    logic [AB-1:0]     s1_dbg_best;
    logic [AB:0]       s1_dbg_margin;

    voxel_class_decider u_dut (
        .clk(clk), .rst(rst), .scores_flat(scores_flat), .scores_valid(scores_valid),
        .scores_ready(scores_ready), .class_enable(class_enable), .gesture(gesture),
        .gesture_valid(gesture_valid), .gesture_ready(gesture_ready),
        .gesture_confidence(gesture_confidence), .drop_count(drop_count),
        .dbg_best_score(dbg_best_score), .dbg_margin(dbg_margin)
    );

    voxel_class_decider #(.NUM_CLASSES(1)) u_one (
        .clk(clk), .rst(rst), .scores_flat(s1_flat), .scores_valid(s1_valid),
        .scores_ready(s1_ready), .class_enable(s1_enable), .gesture(s1_gesture),
        .gesture_valid(s1_gv), .gesture_ready(s1_gready),
        .gesture_confidence(s1_conf), .drop_count(s1_drop),
        .dbg_best_score(s1_dbg_best), .dbg_margin(s1_dbg_margin)
    );

    int tests = 0;
    int fails = 0;
    bit started = 0;
    bit randReady = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level view: argmax over enabled classes, runner-up over the rest.
    task automatic evalVector(input logic [NC*AB-1:0] flat, input logic [NC-1:0] en,
                              output int idx, output bit pass, output int conf);
        longint minv = -(longint'(1) << (AB-1));
        longint best = minv;
        longint second = minv;
        longint margin;
        longint s;
        int cnt = 0;
        idx = 0;
        for (int k = 0; k < NC; k++) begin
            s = longint'($signed(flat[k*AB +: AB]));
            if (en[k]) begin
                cnt++;
                if (s > best) begin
                    best = s;
                    idx = k;
                end
            end
        end
        for (int k = 0; k < NC; k++) begin
            s = longint'($signed(flat[k*AB +: AB]));
            if (en[k] && k != idx && s > second) second = s;
        end
        margin = (cnt <= 1) ? ((longint'(1) << AB) - 1) : (best - second);
        pass = (cnt > 0) && (best > minv) && (best >= THR) && (margin >= MM);
        conf = ((margin >>> CS) > CMAX) ? CMAX : int'(margin >>> CS);
    endtask

    int mBusy, mStreak, mClass, mGv, mG, mConf, mDrop;
    int pIdx, pConf;
    bit pPass;

    always @(posedge clk) begin
        bit emit;
        emit = 1'b0;
        if (!rst) begin
            mBusy = 0; mStreak = 0; mClass = 0;
            mGv = 0; mG = 0; mConf = 0; mDrop = 0;
        end else begin
            if (mBusy == 0) begin
                if (scores_valid) begin
                    evalVector(scores_flat, class_enable, pIdx, pPass, pConf);
                    mBusy = NC + 1;
                end
            end else begin
                mBusy--;
                if (mBusy == 0) begin
                    if (pPass) begin
                        if (pIdx == mClass) mStreak++;
                        else begin
                            mClass = pIdx;
                            mStreak = 1;
                        end
                    end else begin
                        mStreak = 0;
                    end
                    emit = pPass && (mStreak == PC);
                end
            end
            if (emit) begin
                if (mGv == 0 || gesture_ready) begin
                    mGv = 1; mG = pIdx; mConf = pConf;
                end else if (mDrop < 255) begin
                    mDrop++;
                end
            end else if (mGv != 0 && gesture_ready) begin
                mGv = 0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("cyc_scores_ready", scores_ready, (mBusy == 0) ? 1 : 0);
            checkOutput("cyc_gesture_valid", gesture_valid, mGv);
            checkOutput("cyc_gesture", gesture, mG);
            checkOutput("cyc_confidence", gesture_confidence, mConf);
            checkOutput("cyc_drop_count", drop_count, mDrop);
        end
    end

    function automatic logic [NC*AB-1:0] pack4(input int a, input int b, input int c, input int d);
        return {AB'(d), AB'(c), AB'(b), AB'(a)};
    endfunction

    task automatic applyStimulus(input logic [NC*AB-1:0] flat, input logic [NC-1:0] en);
        int waitc = 0;
        while (!scores_ready && waitc < 64) begin
            @(negedge clk);
            waitc++;
        end
        if (!scores_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: got scores_ready=0, expected 1 within 64 cycles");
        end
        scores_flat  = flat;
        class_enable = en;
        scores_valid = 1'b1;
        @(negedge clk);
        scores_valid = 1'b0;
    endtask

    task automatic runVector(input logic [NC*AB-1:0] flat, input logic [NC-1:0] en);
        applyStimulus(flat, en);
        repeat (NC + 1) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        forever begin
            @(negedge clk);
            if (randReady) gesture_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [NC*AB-1:0] vec;
        logic [NC-1:0]    en;
        rst = 1'b0; scores_valid = 1'b0; scores_flat = '0; class_enable = '1;
        gesture_ready = 1'b1;
        s1_flat = '0; s1_valid = 1'b0; s1_enable = 1'b1; s1_gready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_scores_ready", scores_ready, 1);
        checkOutput("reset_gesture_valid", gesture_valid, 0);
        checkOutput("reset_gesture", gesture, 0);
        checkOutput("reset_confidence", gesture_confidence, 0);
        checkOutput("reset_drop_count", drop_count, 0);
        rst = 1'b1;
        @(negedge clk);

        runVector(pack4(10, 50, 40, 5), '1);
        checkOutput("basic_first_no_emit", gesture_valid, 0);
        applyStimulus(pack4(10, 50, 40, 5), '1);
        repeat (NC) @(negedge clk);
        checkOutput("basic_latency_not_yet", gesture_valid, 0);
        @(negedge clk);
        checkOutput("basic_emit_valid", gesture_valid, 1);
        checkOutput("basic_emit_gesture", gesture, 1);
        checkOutput("basic_emit_conf", gesture_confidence, 2);

        runVector(pack4(60, 60, 0, 0), '1);
        checkOutput("tie_first_no_emit", gesture_valid, 0);
        runVector(pack4(60, 60, 0, 0), '1);
        checkOutput("tie_emit_valid", gesture_valid, 1);
        checkOutput("tie_emit_gesture", gesture, 0);
        checkOutput("tie_emit_conf", gesture_confidence, 0);
        runVector(pack4(60, 60, 0, 0), '1);
        checkOutput("tie_no_reemit", gesture_valid, 0);
        runVector(pack4(0, 0, 0, 0), '1);
        checkOutput("tie_break_no_emit", gesture_valid, 0);
        runVector(pack4(60, 60, 0, 0), '1);
        checkOutput("tie_restart_no_emit", gesture_valid, 0);
        runVector(pack4(60, 60, 0, 0), '1);
        checkOutput("tie_restart_emit", gesture_valid, 1);
        checkOutput("tie_restart_gesture", gesture, 0);

        runVector(pack4(0, 90, 70, 0), 4'b1101);
        checkOutput("mask_first_no_emit", gesture_valid, 0);
        runVector(pack4(0, 90, 70, 0), 4'b1101);
        checkOutput("mask_emit_valid", gesture_valid, 1);
        checkOutput("mask_emit_gesture", gesture, 2);
        checkOutput("mask_emit_conf", gesture_confidence, 15);

        runVector(pack4(-5, -100, -100, -100), '1);
        checkOutput("neg_no_emit", gesture_valid, 0);
        runVector(pack4(0, 90, 70, 0), 4'b1101);
        checkOutput("neg_streak_cleared", gesture_valid, 0);
        runVector(pack4(0, 90, 70, 0), 4'b1101);
        checkOutput("neg_then_emit", gesture_valid, 1);

        @(negedge clk);
        gesture_ready = 1'b0;
        checkOutput("bp_start_empty", gesture_valid, 0);
        runVector(pack4(100, 0, 0, 0), '1);
        runVector(pack4(100, 0, 0, 0), '1);
        runVector(pack4(0, 100, 0, 0), '1);
        runVector(pack4(0, 100, 0, 0), '1);
        runVector(pack4(0, 0, 100, 0), '1);
        runVector(pack4(0, 0, 100, 0), '1);
        checkOutput("bp_held_valid", gesture_valid, 1);
        checkOutput("bp_held_gesture", gesture, 0);
        checkOutput("bp_held_conf", gesture_confidence, 15);
        checkOutput("bp_drop_count", drop_count, 2);
        runVector(pack4(0, 0, 0, 100), '1);
        applyStimulus(pack4(0, 0, 0, 100), '1);
        repeat (NC) @(negedge clk);
        gesture_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_replace_valid", gesture_valid, 1);
        checkOutput("bp_replace_gesture", gesture, 3);
        checkOutput("bp_replace_drop", drop_count, 2);

        runVector(pack4(100, 0, 0, 0), '1);
        applyStimulus(pack4(100, 0, 0, 0), '1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst_mid_scores_ready", scores_ready, 1);
        checkOutput("rst_mid_gesture_valid", gesture_valid, 0);
        checkOutput("rst_mid_gesture", gesture, 0);
        checkOutput("rst_mid_confidence", gesture_confidence, 0);
        checkOutput("rst_mid_drop_count", drop_count, 0);
        runVector(pack4(100, 0, 0, 0), '1);
        checkOutput("rst_mid_streak_cleared", gesture_valid, 0);
        runVector(pack4(100, 0, 0, 0), '1);
        checkOutput("rst_mid_then_emit", gesture_valid, 1);

        for (int r = 0; r < 2; r++) begin
            s1_flat  = AB'(50);
            s1_valid = 1'b1;
            @(negedge clk);
            s1_valid = 1'b0;
            repeat (2) @(negedge clk);
            if (r == 0) checkOutput("one_class_first_no_emit", s1_gv, 0);
        end
        checkOutput("one_class_emit_valid", s1_gv, 1);
        checkOutput("one_class_gesture", s1_gesture, 0);
        checkOutput("one_class_conf_saturated", s1_conf, 15);
        checkOutput("one_class_ready", s1_ready, 1);

        randReady = 1'b1;
        vec = pack4(40, 40, 40, 40);
        en = '1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int k = 0; k < NC; k++) begin
                    vec[k*AB +: AB] = AB'(int'($urandom_range(0, 120)) - 20);
                end
                en = ($urandom_range(0, 3) == 0) ? NC'($urandom_range(0, 15)) : '1;
            end
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(vec, en);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                applyStimulus(vec, en);
            end
        end
        randReady = 1'b0;
        gesture_ready = 1'b1;
        repeat (NC + 6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
